// File: rtl/eth_tx_pkg.sv
// Shared types and defaults for the RMII transmit arbiter.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGrantWait,
    StForward,
    StDrain,
    StGap
  } arb_state_e;

  localparam int unsigned IPG_DIBITS_DEFAULT    = 48;
  localparam int unsigned MAX_FRAME_DIBITS      = 6120;
  localparam int unsigned START_TIMEOUT_DEFAULT = 64;

  typedef logic [1:0] dibit_t;

  // Bits needed to count 0..max_val-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from ptr_i+1 (mod N).
module rr_picker #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            found_o,
  output logic [IdxW-1:0] winner_o
);

  logic [IdxW-1:0] idx;

  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    idx      = '0;
    // ptr_i itself is visited last so the previous winner has lowest priority.
    for (int i = 1; i <= int'(N); i++) begin
      idx = IdxW'((int'(ptr_i) + i) % int'(N));
      if (!found_o && req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one RMII TX dibit stream between N sources,
// with inter-packet gap, start timeout and runaway-frame truncation.
module eth_tx_arbiter
  import eth_tx_pkg::*;
#(
  parameter int unsigned N             = 2,
  parameter int unsigned IPG_DIBITS    = IPG_DIBITS_DEFAULT,
  parameter int unsigned MAX_DIBITS    = MAX_FRAME_DIBITS,
  parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   src_axiiv,
  input  logic [2*N-1:0] src_axiid,
  output logic [N-1:0]   gnt,
  output logic           axiov,
  output logic [1:0]     axiod,
  output logic           busy,
  output logic           err_start,
  output logic           err_len
);

  localparam int unsigned IdxW  = cnt_width(N);
  localparam int unsigned CntW  = cnt_width(MAX_DIBITS + 1);
  localparam int unsigned GapW  = cnt_width(IPG_DIBITS + 1);
  localparam int unsigned WaitW = cnt_width(START_TIMEOUT);

  arb_state_e       state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic             axiov_q, axiov_d;
  dibit_t           axiod_q, axiod_d;
  logic             err_start_q, err_start_d;
  logic             err_len_q, err_len_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [WaitW-1:0] wait_q, wait_d;

  logic             pick_found;
  logic [IdxW-1:0]  pick_idx;
  logic             g_valid;
  dibit_t           g_data;

  rr_picker #(
    .N    (N),
    .IdxW (IdxW)
  ) u_rr_picker (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .found_o  (pick_found),
    .winner_o (pick_idx)
  );

  // The pointer doubles as the index of the current grantee.
  assign g_valid = src_axiiv[ptr_q];
  assign g_data  = src_axiid[{ptr_q, 1'b0} +: 2];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    axiov_d     = 1'b0;
    axiod_d     = 2'b00;
    err_start_d = 1'b0;
    err_len_d   = 1'b0;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    wait_d      = wait_q;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          gnt_d   = N'(1) << pick_idx;
          ptr_d   = pick_idx;
          wait_d  = '0;
          state_d = StGrantWait;
        end
      end
      StGrantWait: begin
        if (g_valid) begin
          axiov_d = 1'b1;
          axiod_d = g_data;
          cnt_d   = CntW'(1);
          state_d = StForward;
        end else if (wait_q == WaitW'(START_TIMEOUT - 1)) begin
          gnt_d       = '0;
          err_start_d = 1'b1;
          gap_d       = '0;
          state_d     = StGap;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StForward: begin
        if (!g_valid) begin
          gnt_d   = '0;
          gap_d   = '0;
          state_d = StGap;
        end else if (cnt_q == CntW'(MAX_DIBITS)) begin
          // Keep the grant so the runaway source cannot collide with the next frame.
          err_len_d = 1'b1;
          state_d   = StDrain;
        end else begin
          axiov_d = 1'b1;
          axiod_d = g_data;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (!g_valid) begin
          gnt_d   = '0;
          gap_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == GapW'(IPG_DIBITS - 1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      ptr_q       <= IdxW'(N - 1);
      axiov_q     <= 1'b0;
      axiod_q     <= 2'b00;
      err_start_q <= 1'b0;
      err_len_q   <= 1'b0;
      cnt_q       <= '0;
      gap_q       <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      axiov_q     <= axiov_d;
      axiod_q     <= axiod_d;
      err_start_q <= err_start_d;
      err_len_q   <= err_len_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      wait_q      <= wait_d;
    end
  end

  assign gnt       = gnt_q;
  assign axiov     = axiov_q;
  assign axiod     = axiod_q;
  assign busy      = (state_q != StIdle);
  assign err_start = err_start_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: directed sequence with random frame payloads,
// checked against a frame-level reference model.
module tb_eth_tx_arbiter;
  import eth_tx_pkg::*;

  localparam int N    = 2;
  localparam int IPG  = 48;
  localparam int MAXD = 6120;
  localparam int TMO  = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   src_axiiv;
  logic [2*N-1:0] src_axiid;
  logic [N-1:0]   gnt;
  logic           axiov;
  logic [1:0]     axiod;
  logic           busy;
  logic           err_start;
  logic           err_len;

  eth_tx_arbiter #(
    .N             (N),
    .IPG_DIBITS    (IPG),
    .MAX_DIBITS    (MAXD),
    .START_TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .src_axiiv (src_axiiv),
    .src_axiid (src_axiid),
    .gnt       (gnt),
    .axiov     (axiov),
    .axiod     (axiod),
    .busy      (busy),
    .err_start (err_start),
    .err_len   (err_len)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every forwarded dibit with its cycle stamp, plus error pulse counts.
  dibit_t out_d[$];
  int     out_c[$];
  int     n_err_start = 0;
  int     n_err_len   = 0;
  int     n_idle_bad  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (axiov) begin
        out_d.push_back(axiod);
        out_c.push_back(cyc);
      end else if (axiod != 2'b00) begin
        n_idle_bad <= n_idle_bad + 1;
      end
      if (err_start) n_err_start <= n_err_start + 1;
      if (err_len)   n_err_len   <= n_err_len + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_gnt(output bit got);
    int budget;
    budget = 0;
    while (gnt == '0 && budget < 300) begin
      step(1);
      budget++;
    end
    got = (gnt != '0);
    chk("grant_seen", 32'(got), 1);
  endtask

  // Reference round-robin: first requester after the last winner, wrapping at N.
  int m_last    = N - 1;
  int prev_last = -1;

  function automatic int pick(input logic [N-1:0] r, input int last);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Serve one frame of len dibits from whichever source the model expects to win.
  task automatic do_frame(input int len, input bit keep_req, input bit noise, input bit rnd,
                          output logic [N-1:0] gobs, output int gcyc);
    dibit_t exp_q[$];
    dibit_t d;
    int     w, c0, bad, el0, n_exp;
    bit     got;
    w    = pick(req, m_last);
    gcyc = -1;
    gobs = '0;
    wait_gnt(got);
    if (!got || w < 0) return;
    gcyc = cyc;
    gobs = gnt;
    chk("grant_rr", 32'(gnt), 32'(1) << w);
    m_last = w;
    out_d.delete();
    out_c.delete();
    el0 = n_err_len;
    c0  = cyc;
    for (int k = 0; k < len; k++) begin
      d = rnd ? dibit_t'($urandom_range(0, 3)) : 2'b01;
      src_axiiv[w]          = 1'b1;
      src_axiid[2*w +: 2]   = d;
      if (k < MAXD) exp_q.push_back(d);
      if (noise) begin
        for (int o = 0; o < N; o++) begin
          if (o != w) begin
            src_axiiv[o]        = 1'($urandom_range(0, 1));
            src_axiid[2*o +: 2] = 2'($urandom_range(0, 3));
          end
        end
      end
      step(1);
    end
    if (len > MAXD) chk("gnt_hold_drain", 32'(gnt), 32'(1) << w);
    src_axiiv = '0;
    src_axiid = '0;
    if (!keep_req) req[w] = 1'b0;
    step(3);
    n_exp = exp_q.size();
    chk("frame_len", 32'(out_d.size()), 32'(n_exp));
    bad = 0;
    for (int k = 0; k < n_exp && k < out_d.size(); k++) begin
      if (out_d[k] !== exp_q[k]) bad++;
      if (out_c[k] != c0 + 1 + k) bad++;
    end
    chk("frame_data_timing", 32'(bad), 0);
    chk("err_len_pulses", 32'(n_err_len - el0), 32'(len > MAXD));
    chk("gnt_released", 32'(gnt), 0);
    if (prev_last >= 0 && out_c.size() > 0)
      chk("ipg_min", 32'(out_c[0] - prev_last >= IPG + 3), 1);
    if (out_c.size() > 0) prev_last = out_c[out_c.size() - 1];
  endtask

  initial begin
    logic [N-1:0] gobs;
    int           g, g2, pl, es0;
    bit           got;

    rst       = 1'b1;
    req       = '0;
    src_axiiv = '0;
    src_axiid = '0;
    step(2);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_axiov_axiod", 32'({axiov, axiod}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'({err_start, err_len}), 0);

    // Both request right out of reset: 0 first, then 1 after the gap.
    rst = 1'b0;
    req = 2'b11;
    do_frame(40, 1'b0, 1'b0, 1'b1, gobs, g);
    chk("first_grant_src0", 32'(gobs), 1);
    pl = prev_last;
    do_frame(24, 1'b0, 1'b0, 1'b1, gobs, g2);
    chk("second_grant_src1", 32'(gobs), 2);
    chk("grant_after_ipg", 32'(g2 - pl), IPG + 2);

    // Lone requester 1 with preamble pattern while source 0 toggles noise.
    req[1] = 1'b1;
    do_frame(32, 1'b0, 1'b1, 1'b0, gobs, g);
    chk("preamble_grant", 32'(gobs), 2);

    // Start timeout: source 0 granted but never drives valid.
    req = 2'b11;
    es0 = n_err_start;
    wait_gnt(got);
    g = cyc;
    chk("tmo_grant", 32'(gnt), 1);
    m_last = 0;
    step(TMO - 1);
    chk("tmo_still_granted", 32'(gnt), 1);
    chk("tmo_no_early_err", 32'(err_start), 0);
    step(1);
    chk("tmo_revoked", 32'(gnt), 0);
    chk("tmo_err_start", 32'(err_start), 1);
    chk("tmo_busy_gap", 32'(busy), 1);
    chk("tmo_no_axiov", 32'(out_d.size() > 0 && out_c[out_c.size() - 1] > g), 0);
    req[0] = 1'b0;
    step(1);
    chk("tmo_pulse_end", 32'(err_start), 0);
    do_frame(20, 1'b0, 1'b0, 1'b1, gobs, g2);
    chk("tmo_regrant_src1", 32'(gobs), 2);
    chk("tmo_regrant_cycle", 32'(g2 - g), TMO + IPG + 1);
    chk("err_start_pulses", 32'(n_err_start - es0), 1);

    // Runaway frame gets truncated at MAXD; grant held until valid drops.
    req[1] = 1'b1;
    do_frame(6200, 1'b0, 1'b0, 1'b1, gobs, g);
    chk("trunc_grant", 32'(gobs), 2);

    // Asynchronous reset in the middle of a frame.
    req = 2'b01;
    wait_gnt(got);
    chk("rstmid_grant", 32'(gnt), 1);
    for (int k = 0; k < 100; k++) begin
      src_axiiv[0]   = 1'b1;
      src_axiid[1:0] = 2'($urandom_range(0, 3));
      step(1);
    end
    chk("rstmid_forwarding", 32'(axiov), 1);
    rst = 1'b1;
    #2;
    chk("rstmid_axiov", 32'(axiov), 0);
    chk("rstmid_gnt", 32'(gnt), 0);
    chk("rstmid_busy", 32'(busy), 0);
    src_axiiv = '0;
    src_axiid = '0;
    req       = 2'b11;
    step(2);
    rst       = 1'b0;
    m_last    = N - 1;
    prev_last = -1;

    // Both held continuously: grants must alternate starting with source 0.
    for (int i = 0; i < 6; i++) begin
      do_frame(16, 1'b1, 1'b0, 1'b1, gobs, g);
      chk("alt_order", 32'(gobs), 32'(1) << (i % 2));
    end
    req = '0;
    step(60);
    chk("final_idle_busy", 32'(busy), 0);
    chk("axiod_zero_when_idle", 32'(n_idle_bad), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
Shares the single RMII transmit dibit stream between N frame sources, such as a video-frame streamer and a control/ACK generator. Grants are frame-atomic and round-robin. The block forwards the granted source's dibits to the TX stage, then enforces the Ethernet inter-packet gap before the next grant. It guards the shared link against a granted source that never starts (start timeout) and against a runaway frame (length truncation).

Parameters:
N, 2, number of requesters (2..8)
IPG_DIBITS, 48, idle cycles forced after every frame (96 bit times at 2 bits/cycle)
MAX_DIBITS, 6120, longest legal frame in dibits (preamble+SFD+1522 bytes, x4)
START_TIMEOUT, 64, cycles a grantee has to raise valid before its grant is revoked

Ports:
clk  in  1  50 MHz RMII reference clock
rst  in  1  asynchronous, active-high reset
req  in  N  requester i has a complete frame ready; held high until its frame ends
src_axiiv  in  N  per-source dibit valid
src_axiid  in  2*N  per-source dibit; source i on bits [2i+1:2i]
gnt  out  N  one-hot grant, registered
axiov  out  1  forwarded dibit valid to TX stage, registered
axiod  out  2  forwarded dibit, registered
busy  out  1  high in any state other than IDLE
err_start  out  1  one-cycle pulse: grant revoked by start timeout
err_len  out  1  one-cycle pulse: frame truncated at MAX_DIBITS

Behaviour:
- Reset (async): state IDLE; gnt, axiov, axiod, busy, err_* all 0; counters 0; rr pointer set to N-1 so requester 0 wins first.
- States: IDLE, GRANT_WAIT, FORWARD, DRAIN, GAP.
- IDLE: if req!=0, pick the first set req scanning from pointer+1 mod N. Next cycle: gnt=onehot(winner), pointer=winner, wait counter=0, go to GRANT_WAIT. If req==0, stay.
- GRANT_WAIT: if src_axiiv[g]=1, register that dibit (axiov=1, axiod=data), dibit count=1, go to FORWARD.
  - Otherwise increment the wait counter. When it reaches START_TIMEOUT-1 with no valid: gnt=0, err_start pulse, go to GAP (a gap is still enforced).
- FORWARD: each cycle src_axiiv[g]=1 -> axiov=1, axiod=src dibit, count++. Latency is exactly 1 cycle, source to output.
  - src_axiiv[g]=0 -> axiov=0, axiod=0, gnt=0, gap counter=0, go to GAP. Frame end is the first invalid cycle; valid gaps mid-frame are not supported.
  - If count==MAX_DIBITS and valid is still 1: axiov=0, err_len pulse, go to DRAIN. gnt stays high so the source keeps ownership until it stops.
- DRAIN: outputs idle, source dibits discarded. On src_axiiv[g]=0: gnt=0, go to GAP.
- GAP: axiov=0, axiod=0. After IPG_DIBITS cycles in GAP, go to IDLE. A req arriving during GAP is only evaluated in IDLE, so the first dibit of a new frame is >= IPG_DIBITS+3 cycles after the previous frame's last output dibit.
- Non-granted src_axiiv/src_axiid are ignored in every state. A req dropping while granted does not end the frame; only valid does.
- axiod is 0 whenever axiov=0.
- Counter widths: $clog2 of MAX_DIBITS+1, IPG_DIBITS+1 and START_TIMEOUT, respectively. No wrap is possible inside a state.
- A source whose req is still high in IDLE after its own frame is treated as a new frame and competes normally (round-robin prevents starvation).

Decomposition:
- Package eth_tx_pkg:
  - state enum
  - IPG_DIBITS_DEFAULT=48
  - MAX_FRAME_DIBITS=6120
  - dibit_t (logic [1:0])
- Sub-module rr_picker (purely combinational): inputs req[N] and pointer; outputs found and winner index. Reusable by any future RX-side arbiter.

Test Plan:
- Reset, then req=2'b11 in the same cycle -> gnt=2'b01 first. Source 0 sends 40 dibits and stops -> axiov high for exactly 40 cycles, 1-cycle latency. Then 48 idle cycles, then gnt=2'b10.
- Only req[1] high, source 1 sends 0x55 preamble dibits (2'b01) -> axiod=2'b01 stream. Source 0 toggling valid unheld has no effect on axiov.
- Grant source 0, never raise valid -> after 64 cycles err_start pulses once, gnt=0. After GAP, pending req[1] is granted.
- Source 1 holds valid for 6200 dibits -> axiov high for exactly 6120 cycles, err_len pulses once. gnt[1] stays high until valid drops at 6200, then the 48-cycle gap.
- Assert rst mid-FORWARD (dibit 100) -> same cycle: axiov=0, gnt=0, busy=0. After release with req=2'b11 -> gnt=2'b01.
- Both req held continuously for 6 frames of 16 dibits -> grants alternate 0,1,0,1,0,1. Each inter-frame idle on axiov is >= 48 cycles.
